// File: rtl/cipherbox_uart_pkg.sv
// ---------------------------------------------------------------------------
// cipherbox_uart_pkg
// Shared definitions for the Cipherbox UART transmitter and receiver:
//   - uart_state_e : 3-bit FSM encoding (IDLE=0, START=1, DATA=2, PARITY=3,
//                    STOP=4), common to tx_state and rx_state
//   - DEF_CLK_HZ / DEF_BAUD / DEF_CLKS_PER_BIT : default bit timing
//   - parity_bit() : parity helper used when UART_TX_PARITY_EN is defined
// ---------------------------------------------------------------------------
package cipherbox_uart_pkg;

  localparam int DEF_CLK_HZ       = 50000000;
  localparam int DEF_BAUD         = 115200;
  // Truncating division gives 434 clocks per bit at 50 MHz / 115200.
  localparam int DEF_CLKS_PER_BIT = DEF_CLK_HZ / DEF_BAUD;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity of the byte, inverted when odd parity is selected.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Reusable by both UART directions.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_clr   : hold the count at 0 (used while the line is idle)
//   o_last  : high during the final cycle of the current bit period
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_last
);

  localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_last = (r_cnt == LAST);

  // Bit-period count; wraps to 0 only at the end of a period so every state
  // change (which happens on o_last) starts a fresh period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serialises one byte per valid/ready handshake into an 8N1 UART frame
// (start bit, D0..D7 LSB first, stop bit). Defining UART_TX_PARITY_EN adds a
// parity bit after D7 (8E1 when PARITY_ODD=0, 8O1 when PARITY_ODD=1).
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (aborts a frame, tx goes high)
//   tx_valid : byte request
//   tx_data  : byte to send, sampled only on handshake
//   tx_ready : high only in IDLE
//   tx       : registered serial line, idles high
//   busy     : high from the cycle after acceptance until the frame ends
//   done     : one-cycle pulse in the IDLE cycle following the stop bit
//   tx_state : debug view of the FSM state
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = cipherbox_uart_pkg::DEF_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] tx_state
);

  import cipherbox_uart_pkg::*;

  uart_state_e r_state;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
  logic        r_ready;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif
  logic        w_clr;
  logic        w_last;

  // The counter is held at 0 while idle so START gets a full bit period.
  assign w_clr = (r_state == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_clr),
    .o_last  (w_last)
  );

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tx_ready = r_ready;
  assign tx_state = r_state;

  // Frame FSM: tx is driven one cycle ahead so each bit appears on the edge
  // that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid && r_ready) begin
            r_shift   <= tx_data;
`ifdef UART_TX_PARITY_EN
            r_par     <= parity_bit(tx_data, PARITY_ODD != 0);
`endif
            r_bit_idx <= 3'd0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_last) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_last) begin
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              r_tx      <= r_par;
              r_state   <= ST_PARITY;
`else
              r_tx      <= 1'b1;
              r_state   <= ST_STOP;
`endif
            end else begin
              // Next data bit sits at position 1 before the shift lands.
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_last) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encodings recover to a quiet idle line.
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx. Instance A uses the production bit time
// (434 clocks), instance B a short bit time (4 clocks) with odd parity sense.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int NA = 434;
  localparam int NB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b;
  logic       tx_valid_a, tx_valid_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_ready_a, tx_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;
  logic [2:0] tx_state_a, tx_state_b;

  int  checks   = 0;
  int  failures = 0;
  int  done_cnt_a = 0;
  int  done_cnt_b = 0;
  time t_fall_a = 0, t_rise_a = 0, t_done_a = 0;
  time t_fall_b = 0, t_rise_b = 0, t_done_b = 0;
  time snap_fall [0:11];
  time snap_rise [0:11];
  logic snap_rdy [0:11];

  always #10 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(NA), .PARITY_ODD(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a), .done(done_a), .tx_state(tx_state_a)
  );

  uart_tx #(.CLKS_PER_BIT(NB), .PARITY_ODD(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b), .done(done_b), .tx_state(tx_state_b)
  );

  // Line-event timestamps and done-pulse counters.
  always @(negedge tx_a)  t_fall_a <= $time;
  always @(posedge tx_a)  t_rise_a <= $time;
  always @(posedge done_a) begin t_done_a <= $time; done_cnt_a <= done_cnt_a + 1; end
  always @(negedge tx_b)  t_fall_b <= $time;
  always @(posedge tx_b)  t_rise_b <= $time;
  always @(posedge done_b) begin t_done_b <= $time; done_cnt_b <= done_cnt_b + 1; end

  function automatic logic exp_par(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present a byte; returns 1 ns after the accepting edge.
  task automatic start_frame(input bit sel, input logic [7:0] data, input bit hold);
    @(negedge clk);
    if (sel) begin tx_valid_b = 1'b1; tx_data_b = data; end
    else     begin tx_valid_a = 1'b1; tx_data_a = data; end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (sel) tx_valid_b = 1'b0;
      else     tx_valid_a = 1'b0;
    end
    check("start_tx",    sel ? tx_b       : tx_a,       1'b0);
    check("start_state", sel ? tx_state_b : tx_state_a, 3'd1);
    check("start_busy",  sel ? busy_b     : busy_a,     1'b1);
    check("start_ready", sel ? tx_ready_b : tx_ready_a, 1'b0);
  endtask

  // Samples every bit at mid-period; returns at the negedge of the done cycle.
  task automatic sample_frame(input bit sel, output logic [7:0] d, output logic sb,
                              output logic pb, output logic stb);
    int n;
    n  = sel ? NB : NA;
    pb = 1'b0;
    repeat (n / 2) @(posedge clk);
    @(negedge clk);
    sb = sel ? tx_b : tx_a;
    for (int i = 0; i < 9; i++) begin
      snap_fall[i] = sel ? t_fall_b : t_fall_a;
      snap_rise[i] = sel ? t_rise_b : t_rise_a;
      snap_rdy[i]  = sel ? tx_ready_b : tx_ready_a;
      if (i < 8) begin
        repeat (n) @(posedge clk);
        @(negedge clk);
        d[i] = sel ? tx_b : tx_a;
      end
    end
`ifdef UART_TX_PARITY_EN
    repeat (n) @(posedge clk);
    @(negedge clk);
    pb = sel ? tx_b : tx_a;
`endif
    repeat (n) @(posedge clk);
    @(negedge clk);
    stb = sel ? tx_b : tx_a;
    repeat (n - n / 2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_done_cycle(input bit sel, input string tag);
    check({tag, "_done"},  sel ? done_b     : done_a,     1'b1);
    check({tag, "_ready"}, sel ? tx_ready_b : tx_ready_a, 1'b1);
    check({tag, "_busy"},  sel ? busy_b     : busy_a,     1'b0);
    check({tag, "_state"}, sel ? tx_state_b : tx_state_a, 3'd0);
    check({tag, "_tx"},    sel ? tx_b       : tx_a,       1'b1);
  endtask

  initial begin
    logic [7:0] rd;
    logic       sb, pb, stb;
    int         dc;

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0;
    tx_data_a = 8'h00; tx_data_b = 8'h00;

    // Reset for 3 cycles, then idle state on both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);
    check("rst_tx",    tx_a,       1'b1);
    check("rst_ready", tx_ready_a, 1'b1);
    check("rst_busy",  busy_a,     1'b0);
    check("rst_done",  done_a,     1'b0);
    check("rst_state", tx_state_a, 3'd0);
    check("rst_tx_b",  tx_b,       1'b1);

    // Single byte 8'hD3 at 434 clocks/bit: 0,1,1,0,0,1,0,1,1,1.
    dc = done_cnt_a;
    start_frame(1'b0, 8'hD3, 1'b0);
    sample_frame(1'b0, rd, sb, pb, stb);
    check("d3_start", sb,  1'b0);
    check("d3_data",  rd,  8'hD3);
    check("d3_stop",  stb, 1'b1);
`ifdef UART_TX_PARITY_EN
    check("d3_par_even", pb, 1'b1);
`endif
    check("d3_bit_ns",  snap_rise[1] - snap_fall[1], 64'd8680);
    check("d3_2bit_ns", snap_rise[5] - snap_fall[5], 64'd17360);
    check_done_cycle(1'b0, "d3");
    check("d3_done_ns", t_done_a - snap_fall[0], 64'(FRAME_BITS * NA * 20));
    @(negedge clk);
    check("d3_done_width", done_a, 1'b0);
    check("d3_done_count", done_cnt_a - dc, 32'd1);

    // Back-to-back 8'hA5 then 8'h3C with tx_valid held high.
    dc = done_cnt_a;
    start_frame(1'b0, 8'hA5, 1'b1);
    tx_data_a = 8'h3C;
    sample_frame(1'b0, rd, sb, pb, stb);
    check("a5_data", rd,  8'hA5);
    check("a5_stop", stb, 1'b1);
    check_done_cycle(1'b0, "a5");
    @(posedge clk);
    #1;
    tx_valid_a = 1'b0;
    check("b2b_tx",    tx_a,       1'b0);
    check("b2b_state", tx_state_a, 3'd1);
    check("b2b_gap_ns", t_fall_a - t_done_a, 64'd20);
    sample_frame(1'b0, rd, sb, pb, stb);
    check("3c_start", sb,  1'b0);
    check("3c_data",  rd,  8'h3C);
    check("3c_stop",  stb, 1'b1);
    check_done_cycle(1'b0, "3c");
    repeat (5) @(negedge clk);
    check("b2b_quiet_state", tx_state_a, 3'd0);
    check("b2b_done_count",  done_cnt_a - dc, 32'd2);

    // Busy rejection: 8'hFF requested throughout the 8'h00 frame.
    dc = done_cnt_b;
    start_frame(1'b1, 8'h00, 1'b1);
    tx_data_b = 8'hFF;
    sample_frame(1'b1, rd, sb, pb, stb);
    tx_valid_b = 1'b0;
    check("rej_ready_mid", snap_rdy[4], 1'b0);
    check("rej_data",  rd,  8'h00);
    check("rej_stop",  stb, 1'b1);
`ifdef UART_TX_PARITY_EN
    check("rej_par", pb, exp_par(8'h00, 1'b1));
`endif
    check_done_cycle(1'b1, "rej");
    repeat (3 * NB) @(negedge clk);
    check("rej_no_frame_tx",    tx_b,       1'b1);
    check("rej_no_frame_state", tx_state_b, 3'd0);
    check("rej_done_count",     done_cnt_b - dc, 32'd1);

    // Reset during D3 of 8'h0F, then 8'h81 sent intact.
    dc = done_cnt_b;
    start_frame(1'b1, 8'h0F, 1'b0);
    repeat (4 * NB + NB / 2) @(posedge clk);
    @(negedge clk);
    check("mid_state_data", tx_state_b, 3'd2);
    check("mid_tx_d3",      tx_b,       1'b1);
    rst_n_b = 1'b0;
    #1;
    check("mid_rst_tx",    tx_b,       1'b1);
    check("mid_rst_state", tx_state_b, 3'd0);
    check("mid_rst_busy",  busy_b,     1'b0);
    check("mid_rst_ready", tx_ready_b, 1'b1);
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    start_frame(1'b1, 8'h81, 1'b0);
    sample_frame(1'b1, rd, sb, pb, stb);
    check("post_rst_start", sb,  1'b0);
    check("post_rst_data",  rd,  8'h81);
    check("post_rst_stop",  stb, 1'b1);
`ifdef UART_TX_PARITY_EN
    check("post_rst_par", pb, exp_par(8'h81, 1'b1));
`endif
    check_done_cycle(1'b1, "post_rst");
    check("post_rst_done_count", done_cnt_b - dc, 32'd1);

    // 8'hD3 on the short-bit instance (odd parity sense when enabled).
    start_frame(1'b1, 8'hD3, 1'b0);
    sample_frame(1'b1, rd, sb, pb, stb);
    check("d3b_data", rd,  8'hD3);
    check("d3b_stop", stb, 1'b1);
`ifdef UART_TX_PARITY_EN
    check("d3b_par_odd", pb, 1'b0);
`endif
    check("d3b_done_ns", t_done_b - snap_fall[0], 64'(FRAME_BITS * NB * 20));
    check_done_cycle(1'b1, "d3b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serialises one byte per request into an 8N1 UART frame on a single TX line. It is the transmit counterpart of uart_rx and shares its 50 MHz clock and 115200 baud timing (434 clocks/bit). It sits between the Cipherbox datapath, which produces ciphertext bytes, and the board TX pin. A valid/ready handshake accepts bytes from the datapath.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range is 2 or more.
PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
tx_valid  input  1  byte request from the datapath.
tx_data  input  8  byte to send; sampled only on handshake.
tx_ready  output  1  high only in IDLE; the byte is accepted when tx_valid && tx_ready on a clk edge.
tx  output  1  serial line, registered, idles high.
busy  output  1  high from the cycle after acceptance until the frame ends.
done  output  1  one-cycle pulse when the stop bit completes.
tx_state  output  3  debug FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.

Behaviour:
- Reset (async, rst_n low): state IDLE, tx=1, tx_ready=1, busy=0, done=0, bit counter 0, baud counter 0, shift register 0. Asserting reset mid-frame aborts the frame immediately; tx returns high asynchronously.
- IDLE: tx=1. On an edge with tx_valid && tx_ready:
  - latch tx_data into the shift register;
  - go to START; set tx=0 and busy=1 on that same edge.
  - Latency: tx falls 1 cycle after the handshake cycle.
- START: hold tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with tx=D0.
- DATA:
  - each bit is held CLKS_PER_BIT cycles, LSB first (D0..D7);
  - a 3-bit index counts 0..7;
  - after D7's period, go to PARITY if the macro is defined, else STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle's edge:
  - go to IDLE;
  - clear busy;
  - pulse done=1 for that one cycle;
  - tx_ready is high in the same cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1, with width $clog2(CLKS_PER_BIT). It resets to 0 on every state change and never wraps mid-bit.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity) from tx falling to return to IDLE.
- Back-to-back frames: if tx_valid is held high, the next byte is accepted in the IDLE cycle where done=1. This leaves exactly one idle-high cycle between the stop bit and the next start bit.
- tx_valid while busy is ignored (tx_ready=0). Changes on tx_data during a frame have no effect.
- done and the handshake coincide legally. busy is never high in IDLE.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state is inserted after D7. tx = ^data_latched XOR PARITY_ODD for CLKS_PER_BIT cycles, giving an 8E1 or 8O1 frame of 11 bits.
- Undefined: no PARITY state; encoding 3 stays unused; 8N1 only; the PARITY_ODD parameter is ignored.

Decomposition:
- Package cipherbox_uart_pkg holds:
  - the state enum/localparams (IDLE..STOP, 3 bits), shared with uart_rx so the tx_state and rx_state encodings match;
  - default CLK_HZ=50000000, BAUD=115200 and derived CLKS_PER_BIT=434.
- One sub-module, uart_baud_cnt: the bit-period counter with a clear input and a last-cycle output, reusable by uart_rx.

Test Plan:
- Reset: rst_n low for 3 cycles, then high → tx=1, tx_ready=1, busy=0, done=0, tx_state=0.
- Single byte 8'hD3, CLKS_PER_BIT=434, 20 ns clk:
  - sample tx at mid-bit → 0,1,1,0,0,1,0,1,1,1 (start, LSB-first data, stop);
  - each bit lasts 8680 ns;
  - done is a single pulse 4340 cycles after tx falls.
- Loopback: tx drives uart_rx.rx, send 8'hA5 then 8'h3C with tx_valid held high → rx_data matches each byte, rx done pulses twice, exactly 1 idle cycle between frames.
- Busy rejection: with CLKS_PER_BIT=4, pulse tx_valid with 8'hFF mid-frame of 8'h00 → tx_ready=0, frame bits all 0, no second frame.
- Reset mid-frame: drop rst_n during D3 of 8'h0F → tx=1 immediately, state IDLE; the next byte 8'h81 is sent intact after release.
- UART_TX_PARITY_EN defined, 8'hD3 (five 1s): PARITY_ODD=0 → parity bit 1; PARITY_ODD=1 → parity bit 0. The frame is 11 bits and done occurs 11*CLKS_PER_BIT cycles after start.
